// File: rtl/adc_serial_responder_if.sv
// Serial ADC pin bundle plus the parallel sample inputs and frame status.
// The master modport is the ADC controller side; the slave side is the responder.
interface adc_serial_responder_if #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 12,
   parameter int CH_W   = $clog2(N_CH)
);
   logic                     cs_n;
   logic                     sclk;
   logic                     din;
   logic [N_CH*DATA_W-1:0]   ch_data;
   logic                     dout;
   logic                     dout_oe;
   logic [CH_W-1:0]          cur_channel;
   logic                     frame_done;
   logic                     frame_err;

   modport master (
      output cs_n, sclk, din, ch_data,
      input  dout, dout_oe, cur_channel, frame_done, frame_err
   );

   modport slave (
      input  cs_n, sclk, din, ch_data,
      output dout, dout_oe, cur_channel, frame_done, frame_err
   );
endinterface

// File: rtl/adc_serial_responder.sv
// Slave-side model of an 8-channel 12-bit serial ADC, oversampling cs_n/sclk/din on adc_clk.
// Returns the sample addressed in the previous frame, MSB first, zero-padded to FRAME_BITS.
module adc_serial_responder #(
   parameter int DATA_W      = 12,
   parameter int FRAME_BITS  = 16,
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_POS    = 2
) (
   input  logic                   adc_clk,
   input  logic                   rst_l,
   adc_serial_responder_if.slave  io_adc
);
   localparam int CH_W     = $clog2(N_CH);
   localparam int CNT_W    = $clog2(FRAME_BITS + 1);
   localparam int IDX_W    = $clog2(FRAME_BITS);
   localparam int ADDR_MSB = FRAME_BITS - 1 - ADDR_POS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic                   r_cs_prev;
   logic                   r_sclk_prev;

   state_t                 r_state, w_state_nxt;
   logic [FRAME_BITS-1:0]  r_shreg, w_shreg_nxt;
   logic [FRAME_BITS-1:0]  r_ctrl, w_ctrl_nxt;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [CH_W-1:0]        r_next_ch, w_next_ch_nxt;
   logic [CH_W-1:0]        r_cur_ch, w_cur_ch_nxt;
   logic                   r_dout, w_dout_nxt;
   logic                   r_oe, w_oe_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_err, w_err_nxt;

   logic                   w_cs_s, w_sclk_s, w_din_s;
   logic                   w_cs_fall, w_cs_rise, w_sclk_fall, w_sclk_rise;
   logic [DATA_W-1:0]      w_sel_sample;
   logic [FRAME_BITS-1:0]  w_load;
   logic [CNT_W-1:0]       w_cnt_inc;
   logic [IDX_W-1:0]       w_ctrl_idx;

   // Reset values make the pins look idle (deselected, sclk high) so no edge is seen on release.
   always_ff @(posedge adc_clk or negedge rst_l) begin
      if (!rst_l) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '1;
         r_din_sync  <= '0;
         r_cs_prev   <= 1'b1;
         r_sclk_prev <= 1'b1;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_adc.cs_n};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_adc.sclk};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], io_adc.din};
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_din_s     = r_din_sync[SYNC_STAGES-1];
   assign w_cs_fall   = r_cs_prev & ~w_cs_s;
   assign w_cs_rise   = ~r_cs_prev & w_cs_s;
   assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
   assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;

   assign w_sel_sample = io_adc.ch_data[r_next_ch*DATA_W +: DATA_W];
   assign w_load       = FRAME_BITS'(w_sel_sample);
   assign w_cnt_inc    = r_bit_cnt + 1'b1;
   // Frame bit 0 lands in the MSB of ctrl; only valid while bit_cnt < FRAME_BITS.
   assign w_ctrl_idx   = IDX_W'(FRAME_BITS - 1) - r_bit_cnt[IDX_W-1:0];

   always_ff @(posedge adc_clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state   <= ST_IDLE;
         r_shreg   <= '0;
         r_ctrl    <= '0;
         r_bit_cnt <= '0;
         r_next_ch <= '0;
         r_cur_ch  <= '0;
         r_dout    <= 1'b0;
         r_oe      <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_ctrl    <= w_ctrl_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_next_ch <= w_next_ch_nxt;
         r_cur_ch  <= w_cur_ch_nxt;
         r_dout    <= w_dout_nxt;
         r_oe      <= w_oe_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_ctrl_nxt    = r_ctrl;
      w_bit_cnt_nxt = r_bit_cnt;
      w_next_ch_nxt = r_next_ch;
      w_cur_ch_nxt  = r_cur_ch;
      w_dout_nxt    = r_dout;
      w_oe_nxt      = r_oe;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_oe_nxt = 1'b0;
            if (w_cs_fall) begin
               w_shreg_nxt   = w_load;
               w_cur_ch_nxt  = r_next_ch;
               w_bit_cnt_nxt = '0;
               w_dout_nxt    = w_load[FRAME_BITS-1];
               w_oe_nxt      = 1'b1;
               w_state_nxt   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // SHIFT is left as soon as the count completes, so any cs_n rise here is a short frame.
            if (w_cs_rise) begin
               w_err_nxt   = 1'b1;
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_rise) begin
               w_ctrl_nxt[w_ctrl_idx] = w_din_s;
               w_bit_cnt_nxt          = w_cnt_inc;
               if (w_cnt_inc == CNT_W'(FRAME_BITS)) begin
                  w_next_ch_nxt = w_ctrl_nxt[ADDR_MSB -: CH_W];
                  w_done_nxt    = 1'b1;
                  w_state_nxt   = ST_DONE;
               end
            end else if (w_sclk_fall) begin
               w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
               w_dout_nxt  = r_shreg[FRAME_BITS-2];
            end
         end
         ST_DONE: begin
            if (w_cs_rise) begin
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_fall) begin
               w_oe_nxt = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign io_adc.dout        = r_dout;
   assign io_adc.dout_oe     = r_oe;
   assign io_adc.cur_channel = r_cur_ch;
   assign io_adc.frame_done  = r_done;
   assign io_adc.frame_err   = r_err;
endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: drives SPI-style frames and compares against a
// frame-level model (next channel register plus zero-extended channel word).
module tb_adc_serial_responder;
   localparam int N_CH   = 8;
   localparam int DATA_W = 12;
   localparam int SS     = 2;

   logic adc_clk = 1'b0;
   logic rst_l   = 1'b0;

   adc_serial_responder_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

   adc_serial_responder #(
      .DATA_W(DATA_W), .FRAME_BITS(16), .N_CH(N_CH), .SYNC_STAGES(SS), .ADDR_POS(2)
   ) dut (
      .adc_clk(adc_clk),
      .rst_l  (rst_l),
      .io_adc (bus)
   );

   always #5 adc_clk = ~adc_clk;

   int          checks = 0;
   int          errors = 0;
   int          n_done = 0;
   int          n_err  = 0;
   logic [15:0] rx_word;
   logic [2:0]  m_next_ch;

   always @(posedge adc_clk) begin
      if (bus.frame_done === 1'b1) n_done++;
      if (bus.frame_err === 1'b1) n_err++;
   end

   function automatic logic [15:0] exp_word(input logic [95:0] data, input logic [2:0] ch);
      return {4'b0000, data[int'(ch)*12 +: 12]};
   endfunction

   function automatic logic [95:0] rand_data();
      logic [95:0] d;
      for (int k = 0; k < N_CH; k++) d[k*12 +: 12] = 12'($urandom);
      return d;
   endfunction

   // Frame bit i of din sits in din_word[15-i]; the address bits 2..4 are din_word[13:11].
   function automatic logic [15:0] din_with_addr(input logic [2:0] addr);
      logic [15:0] w;
      w = 16'($urandom);
      w[13:11] = addr;
      return w;
   endfunction

   task automatic start_frame();
      bus.cs_n = 1'b0;
      #50;
   endtask

   task automatic end_frame();
      bus.cs_n = 1'b1;
      #60;
   endtask

   // Each bit: sample dout, present din, sclk fall (slave shifts), sclk rise (slave captures din).
   task automatic shift_bits(input logic [15:0] w, input int first, input int last);
      for (int i = first; i < last; i++) begin
         rx_word[15-i] = bus.dout;
         bus.din  = w[15-i];
         bus.sclk = 1'b0;
         #50;
         bus.sclk = 1'b1;
         #50;
      end
   endtask

   task automatic full_frame(input logic [15:0] w);
      start_frame();
      shift_bits(w, 0, 16);
      end_frame();
      m_next_ch = w[13:11];
   endtask

   task automatic test_reset();
      bus.cs_n = 1'b1; bus.sclk = 1'b1; bus.din = 1'b0; bus.ch_data = '0;
      rst_l = 1'b0;
      #22;
      checks++;
      if ({bus.dout_oe, bus.dout, bus.frame_done, bus.frame_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: oe/dout/done/err=%b required 0000",
                  {bus.dout_oe, bus.dout, bus.frame_done, bus.frame_err});
      end
      checks++;
      if (bus.cur_channel !== 3'd0) begin
         errors++;
         $display("FAIL reset_cur_channel: got %0d required 0", bus.cur_channel);
      end
      rst_l = 1'b1;
      #40;
      m_next_ch = 3'd0;
   endtask

   task automatic test_basic();
      logic oe_start, oe_after;
      bus.ch_data = rand_data();
      bus.ch_data[11:0] = 12'hA5C;
      n_done = 0; n_err = 0;
      start_frame();
      oe_start = bus.dout_oe;
      shift_bits(16'h0000, 0, 16);
      bus.sclk = 1'b0;
      #50;
      oe_after = bus.dout_oe;
      bus.sclk = 1'b1;
      #50;
      end_frame();
      m_next_ch = 3'd0;
      checks++;
      if (rx_word !== 16'h0A5C) begin
         errors++; $display("FAIL basic_word: got %h required 0a5c", rx_word);
      end
      checks++;
      if (bus.cur_channel !== 3'd0) begin
         errors++; $display("FAIL basic_channel: got %0d required 0", bus.cur_channel);
      end
      checks++;
      if (n_done !== 1 || n_err !== 0) begin
         errors++; $display("FAIL basic_pulses: done=%0d err=%0d required 1 0", n_done, n_err);
      end
      checks++;
      if (oe_start !== 1'b1 || oe_after !== 1'b0) begin
         errors++;
         $display("FAIL basic_oe: start=%b after_extra_fall=%b required 1 0", oe_start, oe_after);
      end
   endtask

   task automatic test_addr();
      logic [15:0] e;
      bus.ch_data = rand_data();
      bus.ch_data[5*12 +: 12] = 12'h3F1;
      e = exp_word(bus.ch_data, m_next_ch);
      full_frame(16'h2800);
      checks++;
      if (rx_word !== e) begin
         errors++; $display("FAIL addr_frame1: got %h required %h", rx_word, e);
      end
      full_frame(16'h0000);
      checks++;
      if (rx_word !== 16'h03F1 || bus.cur_channel !== 3'd5) begin
         errors++;
         $display("FAIL addr_frame2: got %h ch %0d required 03f1 ch 5", rx_word, bus.cur_channel);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] e;
      logic [2:0]  ch;
      for (int k = 0; k < N_CH; k++) bus.ch_data[k*12 +: 12] = 12'(12'h100 * k + k);
      n_done = 0;
      for (int f = 0; f < 9; f++) begin
         ch = m_next_ch;
         e  = exp_word(bus.ch_data, ch);
         full_frame(din_with_addr(3'(f)));
         checks++;
         if (rx_word !== e || bus.cur_channel !== ch) begin
            errors++;
            $display("FAIL sweep_frame%0d: got %h ch %0d required %h ch %0d",
                     f, rx_word, bus.cur_channel, e, ch);
         end
      end
      checks++;
      if (n_done !== 9) begin
         errors++; $display("FAIL sweep_done_count: got %0d required 9", n_done);
      end
   endtask

   task automatic test_random();
      logic [15:0] e;
      for (int f = 0; f < 10; f++) begin
         bus.ch_data = rand_data();
         e = exp_word(bus.ch_data, m_next_ch);
         full_frame(16'($urandom));
         checks++;
         if (rx_word !== e) begin
            errors++; $display("FAIL random_frame%0d: got %h required %h", f, rx_word, e);
         end
      end
   endtask

   task automatic test_abort();
      logic [15:0] e;
      int          cyc;
      bus.ch_data = rand_data();
      n_done = 0; n_err = 0;
      start_frame();
      shift_bits(din_with_addr(~m_next_ch), 0, 9);
      bus.cs_n = 1'b1;
      cyc = 0;
      while (bus.dout_oe !== 1'b0 && cyc < 20) begin
         @(posedge adc_clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc > SS + 2) begin
         errors++; $display("FAIL abort_oe_latency: got %0d cycles required <= %0d", cyc, SS + 2);
      end
      #60;
      checks++;
      if (n_err !== 1 || n_done !== 0) begin
         errors++; $display("FAIL abort_pulses: err=%0d done=%0d required 1 0", n_err, n_done);
      end
      e = exp_word(bus.ch_data, m_next_ch);
      full_frame(16'($urandom));
      checks++;
      if (rx_word !== e) begin
         errors++; $display("FAIL abort_next_frame: got %h required %h", rx_word, e);
      end
   endtask

   task automatic test_coherency();
      logic [15:0] e, w;
      logic [2:0]  ch_before;
      int          bad_oe;
      bus.ch_data = rand_data();
      ch_before = bus.cur_channel;
      bad_oe = 0;
      for (int t = 0; t < 5; t++) begin
         bus.sclk = 1'b0;
         #50;
         if (bus.dout_oe !== 1'b0) bad_oe++;
         bus.sclk = 1'b1;
         #50;
         if (bus.dout_oe !== 1'b0) bad_oe++;
      end
      checks++;
      if (bad_oe !== 0 || bus.cur_channel !== ch_before) begin
         errors++;
         $display("FAIL idle_sclk: oe_high_samples=%0d ch %0d required 0 ch %0d",
                  bad_oe, bus.cur_channel, ch_before);
      end
      n_done = 0;
      e = exp_word(bus.ch_data, m_next_ch);
      w = 16'($urandom);
      start_frame();
      shift_bits(w, 0, 8);
      bus.ch_data = ~bus.ch_data;
      shift_bits(w, 8, 16);
      end_frame();
      m_next_ch = w[13:11];
      checks++;
      if (rx_word !== e || n_done !== 1) begin
         errors++;
         $display("FAIL coherency: got %h done %0d required %h done 1", rx_word, n_done, e);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      bus.ch_data = rand_data();
      full_frame(din_with_addr(3'd6));
      n_done = 0; n_err = 0;
      start_frame();
      shift_bits(16'($urandom), 0, 7);
      rst_l = 1'b0;
      #20;
      checks++;
      if (bus.dout_oe !== 1'b0 || bus.cur_channel !== 3'd0) begin
         errors++;
         $display("FAIL midreset_state: oe %b ch %0d required 0 0", bus.dout_oe, bus.cur_channel);
      end
      bus.cs_n = 1'b1;
      bus.sclk = 1'b1;
      #30;
      rst_l = 1'b1;
      #60;
      m_next_ch = 3'd0;
      checks++;
      if (n_done !== 0 || n_err !== 0) begin
         errors++; $display("FAIL midreset_pulses: done %0d err %0d required 0 0", n_done, n_err);
      end
      bus.ch_data[11:0] = 12'h9C3;
      e = exp_word(bus.ch_data, 3'd0);
      full_frame(16'($urandom));
      checks++;
      if (rx_word !== e || n_done !== 1) begin
         errors++;
         $display("FAIL midreset_next_frame: got %h done %0d required %h done 1", rx_word, n_done, e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_basic();
      test_addr();
      test_sweep();
      test_random();
      test_abort();
      test_coherency();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
